game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//   Top-level game controller; sits between the board buttons and the game-physics block.
//   Debounces start and jump buttons and derives the ~60 Hz game tick from the system clock.
//   Runs the IDLE/COUNTDOWN/RUNNING/OVER state machine and issues the start and jump pulses.
//   Keeps score, high score and speed level; speed level is used by the obstacle/render blocks.
// PARAMETERS
//   TICK_DIV          833333  system clocks per game tick (50 MHz -> 60 Hz); >= 2
//   DEBOUNCE_CYC      500000  consecutive stable samples before a button change is accepted; >= 1
//   COUNTDOWN_TICKS   120     ticks spent in COUNTDOWN before RUNNING; >= 1
//   SPEED_STEP_SCORE  100     score points per speed-level increment; >= 1
//   SPEED_MAX         8       saturation value of speed; 1..15
//   SCORE_W           16      width of score / hi_score
// PORTS
//   clk        in   1        system clock
//   rst        in   1        asynchronous, active-high reset
//   btn_start  in   1        raw start button, asynchronous to clk
//   btn_jump   in   1        raw jump button, asynchronous to clk
//   collide    in   1        collision flag from the physics block (level, clk domain)
//   tick       out  1        1-cycle game-tick strobe
//   start_pulse out 1        1-cycle pulse: (re)initialise physics
//   jump_pulse out  1        1-cycle pulse: debounced jump press, RUNNING only
//   run_en     out  1        1 while state == RUNNING
//   state      out  3        0 IDLE, 1 COUNTDOWN, 2 RUNNING, 3 OVER, 4 PAUSED
//   score      out  SCORE_W  current score
//   hi_score   out  SCORE_W  best score since reset
//   speed      out  4        speed level, 1..SPEED_MAX
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; all pulses 0; score=hi_score=0; speed=1; counters cleared.
//   Buttons: 2-FF synchroniser, then counter. Debounced level changes after DEBOUNCE_CYC consecutive
//     samples differing from it; any matching sample clears the counter. A press is the 0->1 edge of
//     the debounced level, held as a 1-cycle internal strobe.
//   Tick: free-running divider 0..TICK_DIV-1; tick=1 in the cycle count==TICK_DIV-1; runs in all states.
//   FSM (all transitions registered):
//     IDLE:      start press -> COUNTDOWN; cd_cnt=COUNTDOWN_TICKS.
//     COUNTDOWN: cd_cnt decrements on each tick. On a tick with cd_cnt==1 -> RUNNING, and
//                start_pulse=1 in that same cycle. Both score and speed clear on COUNTDOWN entry.
//     RUNNING:   on tick: score+1, saturating at all-ones. step_cnt+1; when it reaches SPEED_STEP_SCORE
//                it clears and speed+1, saturating at SPEED_MAX.
//                jump press -> jump_pulse same cycle as strobe (1 cycle after debounce edge).
//                collide=1 -> OVER next cycle; hi_score=max(hi_score, score) on that transition.
//     OVER:      score and speed hold; start press -> COUNTDOWN.
//   Simultaneous events: collide + tick in RUNNING -> collide wins, score not incremented.
//     A start press in RUNNING is ignored (see config).
//     Jump presses outside RUNNING are dropped; they are not queued.
//   collide ignored outside RUNNING. hi_score clears only on rst.
//   Latency: button edge -> strobe = 2 sync + DEBOUNCE_CYC + 1 cycles.
// CONFIGURATION
//   SEQ_PAUSE_EN defined: start press in RUNNING -> PAUSED (state 4).
//     In PAUSED: run_en=0; score, speed and step_cnt frozen; collide and jump ignored.
//     A start press in PAUSED -> RUNNING directly, with no countdown and no start_pulse.
//   SEQ_PAUSE_EN undefined: start press in RUNNING ignored; state 4 unreachable and treated as IDLE.
// TESTING  (TICK_DIV=4, DEBOUNCE_CYC=3, COUNTDOWN_TICKS=2, SPEED_STEP_SCORE=5, SPEED_MAX=3)
//   1 rst mid-RUNNING (score=7) -> outputs at reset values immediately, before the next clk edge;
//     state=0, speed=1, hi_score=0.
//   2 btn_start bounces 1,0,1 then held 1 -> exactly one press. The press comes 2+3+1 clk after the
//     stable edge; state=1.
//   3 From COUNTDOWN -> start_pulse on 2nd tick, same cycle state becomes 2.
//     Tick period is exactly 4 clk.
//   4 RUNNING 12 ticks -> score=12, speed=3. At 15 ticks speed=3 (saturated), score=15.
//   5 collide asserted on a tick cycle at score=9 -> state=3 next cycle; score=9, hi_score=9.
//     A second game ending at score 4 leaves hi_score=9.
//   6 SEQ_PAUSE_EN: start in RUNNING -> state=4, score frozen over 10 ticks, collide ignored.
//     Start again -> state=2 with no start_pulse.
//     Without the macro: the same start press leaves state=2.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: button debounce, game-tick divider, IDLE/COUNTDOWN/RUNNING/OVER FSM, score/speed.
// Optional macro SEQ_PAUSE_EN: a start press in RUNNING pauses the game (state 4).
module game_sequencer #(
  parameter int unsigned TICK_DIV         = 833333,
  parameter int unsigned DEBOUNCE_CYC     = 500000,
  parameter int unsigned COUNTDOWN_TICKS  = 120,
  parameter int unsigned SPEED_STEP_SCORE = 100,
  parameter int unsigned SPEED_MAX        = 8,
  parameter int unsigned SCORE_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_jump,
  input  logic               collide,
  output logic               tick,
  output logic               start_pulse,
  output logic               jump_pulse,
  output logic               run_en,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [3:0]         speed
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned CD_W   = $clog2(COUNTDOWN_TICKS + 1);
  localparam int unsigned STEP_W = $clog2(SPEED_STEP_SCORE + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_OVER      = 3'd3,
    ST_PAUSED    = 3'd4
  } state_t;

  // Index 0 = start button, index 1 = jump button.
  logic [1:0]      w_btn;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_deb;
  logic [1:0]      r_deb_q;
  logic [DB_W-1:0] r_db_cnt [2];
  logic            w_start_press;
  logic            w_jump_press;

  assign w_btn = {btn_jump, btn_start};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle strobes on the rising edge of the debounced levels.
  assign w_start_press = r_deb[0] & ~r_deb_q[0];
  assign w_jump_press  = r_deb[1] & ~r_deb_q[1];

  // Free-running tick divider; r_tick is high while r_div sits at TICK_DIV-1.
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_n;
  logic             r_tick;

  assign w_div_n = (r_div == DIV_W'(TICK_DIV - 1)) ? '0 : r_div + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_n;
      r_tick <= (w_div_n == DIV_W'(TICK_DIV - 1));
    end
  end

  state_t              r_state, w_state_n;
  logic [CD_W-1:0]     r_cd, w_cd_n;
  logic [SCORE_W-1:0]  r_score, w_score_n;
  logic [SCORE_W-1:0]  r_hi, w_hi_n;
  logic [3:0]          r_speed, w_speed_n;
  logic [STEP_W-1:0]   r_step, w_step_n;
  logic                r_start_pulse, w_start_pulse_n;
  logic                r_jump_pulse, w_jump_pulse_n;
  logic                r_run_en;
  logic                w_go_cd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cd          <= '0;
      r_score       <= '0;
      r_hi          <= '0;
      r_speed       <= 4'd1;
      r_step        <= '0;
      r_start_pulse <= 1'b0;
      r_jump_pulse  <= 1'b0;
      r_run_en      <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_cd          <= w_cd_n;
      r_score       <= w_score_n;
      r_hi          <= w_hi_n;
      r_speed       <= w_speed_n;
      r_step        <= w_step_n;
      r_start_pulse <= w_start_pulse_n;
      r_jump_pulse  <= w_jump_pulse_n;
      r_run_en      <= (w_state_n == ST_RUNNING);
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_cd_n          = r_cd;
    w_score_n       = r_score;
    w_hi_n          = r_hi;
    w_speed_n       = r_speed;
    w_step_n        = r_step;
    w_start_pulse_n = 1'b0;
    w_jump_pulse_n  = 1'b0;
    w_go_cd         = 1'b0;

    case (r_state)
      ST_COUNTDOWN: begin
        if (r_tick) begin
          if (r_cd == CD_W'(1)) begin
            w_state_n       = ST_RUNNING;
            w_start_pulse_n = 1'b1;
          end else begin
            w_cd_n = r_cd - 1'b1;
          end
        end
      end
      ST_RUNNING: begin
        w_jump_pulse_n = w_jump_press;
        // Collision outranks a same-cycle tick, so the final score is not bumped.
        if (collide) begin
          w_state_n = ST_OVER;
          w_hi_n    = (r_score > r_hi) ? r_score : r_hi;
`ifdef SEQ_PAUSE_EN
        end else if (w_start_press) begin
          w_state_n = ST_PAUSED;
`endif
        end else if (r_tick) begin
          if (r_score != {SCORE_W{1'b1}}) w_score_n = r_score + 1'b1;
          if (r_step == STEP_W'(SPEED_STEP_SCORE - 1)) begin
            w_step_n = '0;
            if (r_speed != 4'(SPEED_MAX)) w_speed_n = r_speed + 1'b1;
          end else begin
            w_step_n = r_step + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (w_start_press) w_go_cd = 1'b1;
      end
`ifdef SEQ_PAUSE_EN
      ST_PAUSED: begin
        if (w_start_press) w_state_n = ST_RUNNING;
      end
`endif
      default: begin
        if (w_start_press) w_go_cd = 1'b1;
      end
    endcase

    // Every new game starts from a fresh score, speed and step count.
    if (w_go_cd) begin
      w_state_n = ST_COUNTDOWN;
      w_cd_n    = CD_W'(COUNTDOWN_TICKS);
      w_score_n = '0;
      w_speed_n = 4'd1;
      w_step_n  = '0;
    end
  end

  assign tick        = r_tick;
  assign start_pulse = r_start_pulse;
  assign jump_pulse  = r_jump_pulse;
  assign run_en      = r_run_en;
  assign state       = r_state;
  assign score       = r_score;
  assign hi_score    = r_hi;
  assign speed       = r_speed;

endmodule
